wm8731_i2c_responder: RTL

- Synthesizable I2C target that emulates the WM8731 codec's write-only control port; it is the responder for the codec-initialisation I2C initiator.
- Decodes 3-byte write transactions (device address, then 7-bit register address + 9-bit data) into a WM8731-compatible register file.
- Exposes the register file through a read port and decoded control fields.
- Sits in the audio top level as a loopback target: the initiator can be checked on-board without the codec, and the block feeds a codec behavioural model in simulation.

---
 rtl/wm8731_i2c_responder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/wm8731_i2c_responder.sv
// wm8731_i2c_responder: write-only I2C target emulating the WM8731 control port.
// Decodes {dev addr, reg addr + data[8], data[7:0]} writes into a 10-entry
// register file with the codec's power-on defaults, plus the R15 reset command.
// Optional build macro: I2C_RESP_FILTER_EN adds a 3-sample majority filter on
// SCL/SDA after the synchronizers (rejects 1-cycle glitches, +1 cycle latency).
module wm8731_i2c_responder (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_reg_we,
    output logic [3:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_err,
    output logic       o_busy,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_active,
    output logic [5:0] o_sample_ctrl,
    output logic       o_dac_mute
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_IGNORE
    } state_t;

    localparam logic [7:0] DEV_WR = {7'h1A, 1'b0};

    // Power-on contents of the implemented registers
    function automatic logic [8:0] f_default(input logic [3:0] a);
        case (a)
            4'd0:    f_default = 9'h097;
            4'd1:    f_default = 9'h097;
            4'd2:    f_default = 9'h079;
            4'd3:    f_default = 9'h079;
            4'd4:    f_default = 9'h00A;
            4'd5:    f_default = 9'h008;
            4'd6:    f_default = 9'h09F;
            4'd7:    f_default = 9'h00A;
            default: f_default = 9'h000;
        endcase
    endfunction

    logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic       r_scl_d, r_sda_d;
    logic       w_scl, w_sda;
    state_t     r_state, w_state_nxt;
    logic       r_sda_oe, w_oe_nxt;
    logic [3:0] r_bitcnt;
    logic [7:0] r_shift, r_byte1;
    logic [8:0] r_regs [0:9];

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= i_scl;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= i_sda;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef I2C_RESP_FILTER_EN
    logic [1:0] r_scl_hist, r_sda_hist;

    // Sample history for the 2-of-3 majority vote
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_s2};
            r_sda_hist <= {r_sda_hist[0], r_sda_s2};
        end
    end

    assign w_scl = (r_scl_s2 & r_scl_hist[0]) | (r_scl_s2 & r_scl_hist[1]) |
                   (r_scl_hist[0] & r_scl_hist[1]);
    assign w_sda = (r_sda_s2 & r_sda_hist[0]) | (r_sda_s2 & r_sda_hist[1]) |
                   (r_sda_hist[0] & r_sda_hist[1]);
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    // Previous conditioned levels for edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic       w_in_byte, w_bit_shift, w_byte_done, w_commit;
    logic [7:0] w_shift_nxt;
    logic [6:0] w_wr_addr;
    logic [8:0] w_wr_data;

    assign w_scl_rise  = w_scl & ~r_scl_d;
    assign w_scl_fall  = ~w_scl & r_scl_d;
    // START/STOP are judged on the current SCL level so they win over a coincident SCL edge
    assign w_start     = ~w_sda & r_sda_d & w_scl;
    assign w_stop      = w_sda & ~r_sda_d & w_scl;
    assign w_in_byte   = (r_state == S_ADDR) || (r_state == S_BYTE1) || (r_state == S_BYTE2);
    assign w_bit_shift = w_in_byte && w_scl_rise && !w_start && !w_stop;
    assign w_byte_done = w_bit_shift && (r_bitcnt == 4'd7);
    assign w_shift_nxt = {r_shift[6:0], w_sda};
    assign w_commit    = (r_state == S_BYTE2) && w_byte_done;
    assign w_wr_addr   = r_byte1[7:1];
    assign w_wr_data   = {r_byte1[0], w_shift_nxt};

    // Protocol state and ACK driver register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sda_oe <= w_oe_nxt;
        end
    end

    // Next-state logic; ACK states drive on the first SCL fall and release on the second
    always_comb begin
        w_state_nxt = r_state;
        w_oe_nxt    = r_sda_oe;
        if (w_start) begin
            w_state_nxt = S_ADDR;
            w_oe_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: w_oe_nxt = 1'b0;
                S_ADDR: begin
                    if (w_byte_done)
                        w_state_nxt = (w_shift_nxt == DEV_WR) ? S_ADDR_ACK : S_IGNORE;
                end
                S_BYTE1: if (w_byte_done) w_state_nxt = S_ACK1;
                S_BYTE2: if (w_byte_done) w_state_nxt = S_ACK2;
                S_ADDR_ACK, S_ACK1, S_ACK2: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_oe_nxt = 1'b1;
                        end else begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = (r_state == S_ACK1) ? S_BYTE2 : S_BYTE1;
                        end
                    end
                end
                S_IGNORE: w_oe_nxt = 1'b0;
                default: begin
                    w_state_nxt = S_IDLE;
                    w_oe_nxt    = 1'b0;
                end
            endcase
        end
    end

    // Bit counter: runs only inside a byte, restarts on START and outside byte states
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_bitcnt <= 4'd0;
        else if (w_start || !w_in_byte)
            r_bitcnt <= 4'd0;
        else if (w_bit_shift)
            r_bitcnt <= w_byte_done ? 4'd0 : r_bitcnt + 4'd1;
    end

    // MSB-first shifter and first data byte holding register
    always_ff @(posedge i_clk) begin
        if (w_bit_shift)
            r_shift <= w_shift_nxt;
        if ((r_state == S_BYTE1) && w_byte_done)
            r_byte1 <= w_shift_nxt;
    end

    // Register file and commit strobes; reset overrides a coincident R15 write
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 10; i++)
                r_regs[i] <= f_default(4'(i));
            o_reg_we   <= 1'b0;
            o_err      <= 1'b0;
            o_reg_addr <= 4'd0;
            o_reg_data <= 9'd0;
        end else begin
            o_reg_we <= 1'b0;
            o_err    <= 1'b0;
            if (w_commit) begin
                if (w_wr_addr <= 7'd9) begin
                    r_regs[w_wr_addr[3:0]] <= w_wr_data;
                    o_reg_we   <= 1'b1;
                    o_reg_addr <= w_wr_addr[3:0];
                    o_reg_data <= w_wr_data;
                end else if (w_wr_addr == 7'd15) begin
                    for (int i = 0; i < 10; i++)
                        r_regs[i] <= f_default(4'(i));
                    o_reg_we   <= 1'b1;
                    o_reg_addr <= 4'd15;
                    o_reg_data <= w_wr_data;
                end else begin
                    o_err <= 1'b1;
                end
            end
        end
    end

    assign o_sda_oe      = r_sda_oe;
    assign o_busy        = (r_state != S_IDLE);
    assign o_rd_data     = (i_rd_addr <= 4'd9) ? r_regs[i_rd_addr] : 9'h000;
    assign o_active      = r_regs[9][0];
    assign o_sample_ctrl = r_regs[8][5:0];
    assign o_dac_mute    = r_regs[5][3];

endmodule
